// File: rtl/exec_issue_queue_pkg.sv
// ----------------------------------------------------------------------------
// exec_issue_queue_pkg
//
// Purpose:
//   Shared constants and helpers for the in-order issue buffer that sits
//   directly upstream of exec.
//
// Contents:
//   LEN_EXEC_INFO : width of one packed exec_info word. It must match the
//                   width used by exec and by instruction decode.
//   IQ_DEPTH      : default number of queue entries.
//   is_pow2()     : elaboration-time check that a depth is a power of two
//                   and at least 2.
// ----------------------------------------------------------------------------
package exec_issue_queue_pkg;

    // Width of one packed exec_info word, shared with exec and decode.
    localparam int LEN_EXEC_INFO = 32;

    // Default queue depth. The pointers rely on natural wrap, so any depth
    // used here must be a power of two.
    localparam int IQ_DEPTH = 4;

    // True when value is a power of two and at least 2.
    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage : exec_issue_queue_pkg

// File: rtl/exec_issue_queue_ptr.sv
// ----------------------------------------------------------------------------
// exec_iq_ptr
//
// Purpose:
//   Next-state logic for the issue queue read pointer, write pointer and
//   occupancy count. This block is purely combinational. The registers live
//   in exec_issue_queue.
//
// Ports:
//   push      in   1      an entry is written this cycle
//   pop       in   1      the head entry is issued to exec this cycle
//   flush     in   1      drop every entry; highest priority
//   rd_ptr_q  in   PW     current read pointer
//   wr_ptr_q  in   PW     current write pointer
//   count_q   in   CW     current occupancy
//   rd_ptr_d  out  PW     next read pointer
//   wr_ptr_d  out  PW     next write pointer
//   count_d   out  CW     next occupancy
// ----------------------------------------------------------------------------
module exec_iq_ptr
    import exec_issue_queue_pkg::*;
#(
    parameter  int DEPTH = IQ_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [PW-1:0] rd_ptr_q,
    input  logic [PW-1:0] wr_ptr_q,
    input  logic [CW-1:0] count_q,
    output logic [PW-1:0] rd_ptr_d,
    output logic [PW-1:0] wr_ptr_d,
    output logic [CW-1:0] count_d
);

    // Pointers advance independently and wrap modulo DEPTH through their
    // natural width. The count is kept separately so that full and empty
    // never alias. A flush zeroes everything and overrides any push or pop
    // in the same cycle.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end

            // A push and a pop in the same cycle leave the occupancy unchanged.
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

endmodule : exec_iq_ptr

// File: rtl/exec_issue_queue.sv
// ----------------------------------------------------------------------------
// exec_issue_queue
//
// Purpose:
//   In-order issue buffer in front of exec. It holds up to DEPTH packed
//   exec_info words from decode/operand-read and offers the oldest one to
//   exec through the order/accepted handshake. An entry is removed only when
//   exec accepts it. A flush (branch hazard or jump redirect) discards every
//   queued entry.
//
// Ports:
//   clk        in   1         clock; all state updates on posedge
//   rst        in   1         synchronous, active-high reset
//   in_valid   in   1         upstream offers in_info this cycle
//   in_ready   out  1         queue can take an entry (not full)
//   in_info    in   LEN_EI    exec_info word to enqueue
//   flush      in   1         drop all entries (redirect)
//   exec_busy  in   1         exec has a multi-cycle op in flight
//   order      out  1         head entry offered to exec
//   accepted   in   1         exec took the head entry this cycle
//   exec_info  out  LEN_EI    head entry; all-zero when empty
//   count      out  CW        occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module exec_issue_queue
    import exec_issue_queue_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int LEN_EI = LEN_EXEC_INFO
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LEN_EI-1:0]        in_info,
    input  logic                     flush,
    input  logic                     exec_busy,
    output logic                     order,
    input  logic                     accepted,
    output logic [LEN_EI-1:0]        exec_info,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    // Pointer wrap depends on DEPTH being a power of two.
    if (!is_pow2(DEPTH)) begin : g_depth_check
        $error("exec_issue_queue: DEPTH must be a power of two and >= 2");
    end

    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     wr_ptr_d;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [LEN_EI-1:0] mem_q [DEPTH];
    logic [LEN_EI-1:0] mem_d [DEPTH];

    logic              empty;
    logic              full;
    logic              push;
    logic              pop;

    // Handshake decode. Every output here comes only from registered state
    // plus exec_busy and flush, so accepted cannot loop back into order.
    // A full queue refuses in_valid even in a cycle where the head is popped,
    // which keeps in_ready a function of registered state alone.
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        in_ready  = ~full;
        order     = ~empty & ~exec_busy & ~flush;
        push      = in_valid & in_ready & ~flush;
        pop       = accepted & order;
        exec_info = empty ? '0 : mem_q[rd_ptr_q];
        count     = count_q;
    end

    // Entry storage. A push writes the slot at the write pointer. The head
    // slot is therefore never written while it is being presented, so
    // exec_info stays stable until exec accepts it.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_info;
        end
    end

    // Pointer and count next-state logic. A flush clears everything.
    exec_iq_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .rd_ptr_q (rd_ptr_q),
        .wr_ptr_q (wr_ptr_q),
        .count_q  (count_q),
        .rd_ptr_d (rd_ptr_d),
        .wr_ptr_d (wr_ptr_d),
        .count_d  (count_d)
    );

    // Control state registers. Reset has the same effect as a flush and
    // wins over any activity in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage registers have no reset. A slot is only read after it has
    // been written, so stale contents are never visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifndef SYNTHESIS
    // Exec must not accept while busy. The RTL already ignores such a pulse
    // because order is low while exec_busy is high. This check makes the
    // protocol violation visible in simulation.
    always_ff @(posedge clk) begin
        if (!rst && accepted && exec_busy) begin
            $error("exec_issue_queue: accepted asserted while exec_busy=1");
        end
    end
`endif

endmodule : exec_issue_queue

// File: tb/tb_exec_issue_queue.sv
// ----------------------------------------------------------------------------
// tb_exec_issue_queue
//
// Self-checking bench for exec_issue_queue with DEPTH=4 and 32-bit entries.
// It runs the directed vectors from a table first, then a streaming sequence,
// then random traffic compared against a simple FIFO reference model.
// ----------------------------------------------------------------------------
module tb_exec_issue_queue;

    localparam int DEPTH  = 4;
    localparam int LEN_EI = 32;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [LEN_EI-1:0] in_info;
    logic              flush;
    logic              exec_busy;
    logic              order;
    logic              accepted;
    logic [LEN_EI-1:0] exec_info;
    logic [2:0]        count;

    int checks = 0;
    int errors = 0;

    exec_issue_queue #(
        .DEPTH  (DEPTH),
        .LEN_EI (LEN_EI)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_info   (in_info),
        .flush     (flush),
        .exec_busy (exec_busy),
        .order     (order),
        .accepted  (accepted),
        .exec_info (exec_info),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One directed vector: the inputs for a cycle and the outputs expected
    // before the next clock edge.
    typedef struct {
        logic        rst;
        logic        in_valid;
        logic [31:0] in_info;
        logic        flush;
        logic        exec_busy;
        logic        accepted;
        logic [2:0]  exp_count;
        logic        exp_order;
        logic        exp_ready;
        logic [31:0] exp_info;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] WA  = 32'hA000_000A;
    localparam logic [31:0] WB  = 32'hB000_000B;
    localparam logic [31:0] WC  = 32'hC000_000C;
    localparam logic [31:0] WD  = 32'hD000_000D;
    localparam logic [31:0] WE  = 32'hE000_000E;
    localparam logic [31:0] WP  = 32'h1111_0001;
    localparam logic [31:0] WQ  = 32'h2222_0002;
    localparam logic [31:0] WR1 = 32'h3333_0001;
    localparam logic [31:0] WR2 = 32'h3333_0002;
    localparam logic [31:0] WR3 = 32'h3333_0003;
    localparam logic [31:0] WX  = 32'hDEAD_BEEF;
    localparam logic [31:0] WY  = 32'h7777_0007;
    localparam logic [31:0] WZ  = 32'h8888_0001;
    localparam logic [31:0] WZ2 = 32'h8888_0002;
    localparam logic [31:0] WZ3 = 32'h8888_0003;
    localparam logic [31:0] W0  = 32'h0000_0000;

    function automatic void addVec(input logic r, input logic v, input logic [31:0] info,
                                   input logic f, input logic b, input logic a,
                                   input logic [2:0] ec, input logic eo, input logic er,
                                   input logic [31:0] ei);
        vec_t t;
        t.rst = r; t.in_valid = v; t.in_info = info; t.flush = f; t.exec_busy = b;
        t.accepted = a; t.exp_count = ec; t.exp_order = eo; t.exp_ready = er; t.exp_info = ei;
        vecs.push_back(t);
    endfunction

    function automatic logic [31:0] streamWord(input int i);
        return 32'h5000_0000 + 32'(i);
    endfunction

    // Drive one cycle of inputs, just after the active clock edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [31:0] info,
                                 input logic f, input logic b, input logic a);
        rst       = r;
        in_valid  = v;
        in_info   = info;
        flush     = f;
        exec_busy = b;
        accepted  = a;
    endtask

    task automatic checkField(input string tag, input string field, input int idx,
                              input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s.%s[%0d]: got %h, expected %h", tag, field, idx, actual, expected);
        end
    endtask

    // Sample the outputs at the falling edge, then advance past the next
    // rising edge.
    task automatic checkOutput(input string tag, input int idx, input logic [2:0] exp_count,
                               input logic exp_order, input logic exp_ready,
                               input logic [31:0] exp_info);
        @(negedge clk);
        checkField(tag, "count",     idx, 32'(count),    32'(exp_count));
        checkField(tag, "order",     idx, 32'(order),    32'(exp_order));
        checkField(tag, "in_ready",  idx, 32'(in_ready), 32'(exp_ready));
        checkField(tag, "exec_info", idx, exec_info,     exp_info);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] model_q[$];

    initial begin
        // Reset and in_valid: first reset cycle (state unknown before it).
        applyStimulus(1'b1, 1'b1, WA, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Second reset cycle, then fill/drain with a refused 5th push.
        addVec(1'b1, 1'b1, WA,  1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, W0);
        addVec(1'b0, 1'b0, W0,  1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, W0);
        addVec(1'b0, 1'b1, WA,  1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, W0);
        addVec(1'b0, 1'b1, WB,  1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, WA);
        addVec(1'b0, 1'b1, WC,  1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, WA);
        addVec(1'b0, 1'b1, WD,  1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, WA);
        addVec(1'b0, 1'b1, WE,  1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, WA);
        addVec(1'b0, 1'b1, WE,  1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, WA);
        addVec(1'b0, 1'b0, W0,  1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, WB);
        addVec(1'b0, 1'b0, W0,  1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, WC);
        addVec(1'b0, 1'b0, W0,  1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, WD);
        // Accept while empty is ignored.
        addVec(1'b0, 1'b0, W0,  1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, W0);
        addVec(1'b0, 1'b0, W0,  1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, W0);
        addVec(1'b0, 1'b0, W0,  1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, W0);
        // exec_busy holds order low while the head stays visible.
        addVec(1'b0, 1'b1, WP,  1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, W0);
        addVec(1'b0, 1'b1, WQ,  1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, WP);
        addVec(1'b0, 1'b0, W0,  1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, WP);
        addVec(1'b0, 1'b0, W0,  1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, WP);
        addVec(1'b0, 1'b0, W0,  1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, WP);
        addVec(1'b0, 1'b0, W0,  1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, WP);
        addVec(1'b0, 1'b0, W0,  1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, WP);
        addVec(1'b0, 1'b0, W0,  1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, WQ);
        addVec(1'b0, 1'b0, W0,  1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, W0);
        // Flush with count=3 plus same-cycle push X and accepted.
        addVec(1'b0, 1'b1, WR1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, W0);
        addVec(1'b0, 1'b1, WR2, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, WR1);
        addVec(1'b0, 1'b1, WR3, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, WR1);
        addVec(1'b0, 1'b1, WX,  1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, WR1);
        addVec(1'b0, 1'b1, WY,  1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, W0);
        addVec(1'b0, 1'b0, W0,  1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, WY);
        addVec(1'b0, 1'b0, W0,  1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, WY);
        addVec(1'b0, 1'b0, W0,  1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, W0);
        // Reset in the middle of operation.
        addVec(1'b0, 1'b1, WZ,  1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, W0);
        addVec(1'b0, 1'b1, WZ2, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, WZ);
        addVec(1'b1, 1'b1, WZ3, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, WZ);
        addVec(1'b0, 1'b0, W0,  1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, W0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].in_valid, vecs[i].in_info,
                          vecs[i].flush, vecs[i].exec_busy, vecs[i].accepted);
            checkOutput("table", i, vecs[i].exp_count, vecs[i].exp_order,
                        vecs[i].exp_ready, vecs[i].exp_info);
        end

        // Steady stream: one push and one accept per cycle. The pointers wrap.
        applyStimulus(1'b0, 1'b1, streamWord(0), 1'b0, 1'b0, 1'b0);
        checkOutput("stream", 0, 3'd0, 1'b0, 1'b1, W0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 1'b1, streamWord(i), 1'b0, 1'b0, 1'b1);
            checkOutput("stream", i, 3'd1, 1'b1, 1'b1, streamWord(i - 1));
        end
        applyStimulus(1'b0, 1'b0, W0, 1'b0, 1'b0, 1'b1);
        checkOutput("stream", 11, 3'd1, 1'b1, 1'b1, streamWord(10));
        applyStimulus(1'b0, 1'b0, W0, 1'b0, 1'b0, 1'b0);
        checkOutput("stream", 12, 3'd0, 1'b0, 1'b1, W0);

        // Random traffic against a FIFO model. The queue is empty at this point.
        model_q.delete();
        for (int n = 0; n < 400; n++) begin
            logic        r;
            logic        f;
            logic        b;
            logic        v;
            logic        a;
            logic [31:0] info;
            logic [2:0]  e_count;
            logic        e_order;
            logic        e_ready;
            logic [31:0] e_info;

            r    = ($urandom_range(63) == 0);
            f    = ($urandom_range(15) == 0);
            b    = ($urandom_range(3) == 0);
            v    = ($urandom_range(1) == 1);
            a    = b ? 1'b0 : ($urandom_range(1) == 1);
            info = $urandom();

            e_count = 3'(model_q.size());
            e_ready = (model_q.size() < DEPTH);
            e_order = (model_q.size() != 0) && !b && !f;
            e_info  = (model_q.size() != 0) ? model_q[0] : W0;

            applyStimulus(r, v, info, f, b, a);
            checkOutput("rand", n, e_count, e_order, e_ready, e_info);

            if (r || f) begin
                model_q.delete();
            end else begin
                if (a && e_order) begin
                    void'(model_q.pop_front());
                end
                if (v && e_ready) begin
                    model_q.push_back(info);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_exec_issue_queue
